mux4_rr_arbiter: RTL and testbench
==================================

// Module: mux4_rr_arbiter
// PURPOSE
//  Round-robin arbiter/scheduler that shares the 4:1 bit multiplexer (mux4) between four requesters.
//  Each requester raises req[i] and presents its data bit d[i].
//  The block grants one owner at a time, drives the mux select pair (sel1 = MSB, sel2 = LSB of owner index)
//  and returns a registered data_out/data_vld.
//  Sits between requesting agents and the shared mux4 instance.
// PARAMETERS
//  MAX_HOLD  4  max consecutive grant cycles per owner before forced rotation (>=1)
//  HOLD_W    3  width of hold counter; must satisfy 2**HOLD_W > MAX_HOLD
// PORTS
//  clk       in   1  single clock, rising edge
//  rst_n     in   1  asynchronous, active-low reset
//  req       in   4  request per requester, level, held while wanting access
//  d         in   4  data bit per requester (d[0]..d[3] -> mux inputs d0..d3)
//  gnt       out  4  one-hot grant, registered; 4'b0000 when idle
//  sel1      out  1  mux select MSB = owner index[1], registered
//  sel2      out  1  mux select LSB = owner index[0], registered
//  data_out  out  1  registered mux output of current owner
//  data_vld  out  1  high when data_out carries a granted requester's bit
// BEHAVIOUR
//  Reset (async, rst_n=0): gnt=0, sel1=sel2=0, data_out=0, data_vld=0, state=IDLE, rr pointer=0, hold_cnt=0.
//    Takes effect immediately, also mid-grant; first grant after release is evaluated from pointer=0.
//  States: IDLE (no owner), GRANT (one owner). Two-state FSM, binary encoded.
//  Arbitration latency: req sampled at edge n -> gnt/sel valid after edge n+1 (1 cycle).
//  Pick order: search starts at pointer, ascending, wraps 3->0; first asserted req wins.
//  IDLE: any req -> GRANT to picked index, pointer <= winner+1 (mod 4), hold_cnt <= 0; no req -> stay IDLE.
//  GRANT, owner keeps req and hold_cnt < MAX_HOLD-1: keep grant, hold_cnt++.
//  GRANT, owner drops req OR hold_cnt == MAX_HOLD-1: re-pick from pointer (owner+1) same edge.
//    Another req -> back-to-back handover, no idle cycle.
//    Only the owner requesting (expiry) -> owner re-granted, hold_cnt <= 0.
//    No req -> IDLE, gnt=0 next cycle.
//  Owner dropping req and another raising in the same cycle: the new requester is eligible in that same pick.
//  gnt only ever one-hot or zero; sel1/sel2 hold last value while IDLE.
//  Datapath: mux4 output sampled each edge.
//    data_out <= mux(d, sel1, sel2); data_vld <= |gnt.
//    Latency: data_vld follows gnt by 1 cycle.
//    While IDLE, data_out holds and data_vld=0.
//  MAX_HOLD=1: rotation every cycle whenever more than one requester is active.
// STRUCTURE
//  Include mux4_arb_defs.vh: state encodings ST_IDLE/ST_GRANT, NREQ=4, IDX_W=2.
//  Sub-module rr_pick4: combinational rotate-priority picker (req[3:0], ptr[1:0] -> found, idx[1:0]).
//  Reuse existing mux4 for the data select; FSM, pointer, hold counter and output regs in this top.
// TESTING
//  1 Reset then req=4'b1111, MAX_HOLD=4 held -> gnt 0001 x4, 0010 x4, 0100 x4, 1000 x4, repeat;
//    {sel1,sel2} = 00, 01, 10, 11.
//  2 req=4'b0100 alone for 10 cycles -> gnt=0100 throughout (re-grant at expiry, no gap);
//    data_out=d[2] one cycle later, data_vld=1.
//  3 Owner 1 drops req while req[3]=1 -> next edge gnt=1000, no idle cycle; pointer=0 afterwards.
//  4 All req drop -> gnt=0000 next edge, data_vld=0 the edge after, sel pair unchanged.
//  5 Assert rst_n=0 mid-grant (gnt=0010) -> gnt, data_vld, data_out, sel clear immediately;
//    after release with req=1010, first gnt=0010.
//  6 d toggled per owner, all 16 req patterns swept -> data_out always equals d[owner] of previous cycle;
//    gnt never multi-hot.

Source files
------------

// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter in front of the 4:1 bit mux.
// State encodings, requester count/index width and the mux select function.
package mux4_rr_arbiter_pkg;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned IDX_W = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    // 4:1 bit mux: sel1 is the MSB of the input index, sel2 the LSB.
    function automatic logic mux4(input logic [NREQ-1:0] din, input logic sel1, input logic sel2);
        return din[{sel1, sel2}];
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational rotate-priority picker: first asserted request at or after ptr, wrapping 3->0.
module rr_pick4
    import mux4_rr_arbiter_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] cand;

    // Walk the rotation backwards so the candidate closest to ptr overwrites the others.
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        cand  = '0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            cand = ptr + IDX_W'(k);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 bit mux between four requesters,
// with a hold limit per owner and a registered data_out/data_vld stage.
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned HOLD_W   = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] d,
    output logic [NREQ-1:0] gnt,
    output logic            sel1,
    output logic            sel2,
    output logic            data_out,
    output logic            data_vld
);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;

    logic              pick_found;
    logic [IDX_W-1:0]  pick_idx;

    // While granted ptr already equals owner+1, so one picker serves both states.
    rr_pick4 u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        gnt_d   = gnt_q;

        case (state_q)
            ST_IDLE: begin
                gnt_d = '0;
                if (pick_found) begin
                    state_d = ST_GRANT;
                    owner_d = pick_idx;
                    ptr_d   = pick_idx + IDX_W'(1);
                    hold_d  = '0;
                    gnt_d   = NREQ'(1) << pick_idx;
                end
            end
            ST_GRANT: begin
                if (req[owner_q] && (hold_q < HOLD_W'(MAX_HOLD - 1))) begin
                    hold_d = hold_q + HOLD_W'(1);
                end else if (pick_found) begin
                    // Handover or expiry re-grant; the search wraps back to the owner last.
                    owner_d = pick_idx;
                    ptr_d   = pick_idx + IDX_W'(1);
                    hold_d  = '0;
                    gnt_d   = NREQ'(1) << pick_idx;
                end else begin
                    state_d = ST_IDLE;
                    hold_d  = '0;
                    gnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // Data stage samples the mux through the registered select; holds while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= 1'b0;
            data_vld <= 1'b0;
        end else begin
            if (|gnt_q) begin
                data_out <= mux4(d, owner_q[1], owner_q[0]);
            end
            data_vld <= |gnt_q;
        end
    end

    assign gnt  = gnt_q;
    assign sel1 = owner_q[1];
    assign sel2 = owner_q[0];

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: stimulus pushes expected outputs per edge,
// a monitor pops and compares one entry after every rising edge.
module tb_mux4_rr_arbiter;

    localparam int unsigned MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] d;
    logic [3:0] gnt;
    logic       sel1, sel2, data_out, data_vld;

    always #5 clk = ~clk;

    mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .HOLD_W(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .d        (d),
        .gnt      (gnt),
        .sel1     (sel1),
        .sel2     (sel2),
        .data_out (data_out),
        .data_vld (data_vld)
    );

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       dvld;
        logic       dout;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model of the visible outputs, used for the pattern sweep.
    logic [3:0] m_gnt;
    logic [1:0] m_owner;
    logic       m_dout, m_dvld;
    int         m_ptr, m_hold;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_gnt = '0; m_owner = '0; m_dout = 1'b0; m_dvld = 1'b0; m_ptr = 0; m_hold = 0;
    endtask

    task automatic model_step(input logic [3:0] r, input logic [3:0] dd);
        logic busy;
        bit   repick;
        int   w;
        busy = (m_gnt != 4'b0000);
        if (busy) m_dout = dd[m_owner];
        m_dvld = busy;
        repick = !busy || !r[m_owner] || (m_hold == int'(MAX_HOLD) - 1);
        if (!repick) begin
            m_hold++;
        end else begin
            w = -1;
            for (int k = 0; k < 4; k++)
                if (w < 0 && r[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
            if (w < 0) begin
                m_gnt = '0;
                m_hold = 0;
            end else begin
                m_gnt   = 4'(1 << w);
                m_owner = 2'(w);
                m_ptr   = (w + 1) % 4;
                m_hold  = 0;
            end
        end
    endtask

    // Apply one cycle of inputs and queue the outputs expected after the next rising edge.
    task automatic drive(input logic rst_v, input logic [3:0] r, input logic [3:0] dd,
                         input bit use_model, input logic [3:0] eg, input logic [1:0] es,
                         input logic ev, input logic eo, input string nm);
        exp_t e;
        @(negedge clk);
        rst_n = rst_v;
        req   = r;
        d     = dd;
        if (!rst_v) model_reset();
        else        model_step(r, dd);
        if (use_model) e = '{m_gnt, m_owner, m_dvld, m_dout, nm};
        else           e = '{eg, es, ev, eo, nm};
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.name, ".gnt"},  8'(gnt),           8'(e.gnt));
                check({e.name, ".sel"},  8'({sel1, sel2}),  8'(e.sel));
                check({e.name, ".vld"},  8'(data_vld),      8'(e.dvld));
                check({e.name, ".dout"}, 8'(data_out),      8'(e.dout));
                check({e.name, ".onehot"}, 8'($onehot0(gnt)), 8'd1);
            end
        end
    end

    initial begin : stimulus
        logic [3:0] td;
        int         o;
        rst_n = 1'b1;
        req   = '0;
        d     = '0;
        model_reset();
        #1 rst_n = 1'b0;
        #2;
        check("reset.gnt",  8'(gnt), 8'h0);
        check("reset.sel",  8'({sel1, sel2}), 8'h0);
        check("reset.vld",  8'(data_vld), 8'h0);
        check("reset.dout", 8'(data_out), 8'h0);
        drive(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "reset_hold");

        // All four requesting: four grants each, ascending rotation.
        td = 4'b1010;
        for (int i = 1; i <= 20; i++) begin
            o = ((i - 2) / 4) % 4;
            drive(1'b1, 4'b1111, td, 1'b0, 4'(1 << (((i - 1) / 4) % 4)), 2'(((i - 1) / 4) % 4),
                  1'(i > 1), (i > 1) ? td[o] : 1'b0, "rr_all");
        end

        // Lone requester re-granted at expiry without a gap.
        for (int i = 21; i <= 30; i++)
            drive(1'b1, 4'b0100, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, (i == 21) ? 1'b0 : 1'b1, "lone_req2");

        // Owner 1 drops while 3 requests: immediate handover.
        drive(1'b1, 4'b0010, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, "own1_a");
        drive(1'b1, 4'b0010, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b1, "own1_b");
        drive(1'b1, 4'b1000, 4'b0010, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b1, "handover3");

        // All requests drop: idle, sel and data_out hold.
        drive(1'b1, 4'b0000, 4'b1000, 1'b0, 4'b0000, 2'd3, 1'b1, 1'b1, "idle_a");
        drive(1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd3, 1'b0, 1'b1, "idle_b");
        // Pointer is 0 after owner 3, so 0011 picks requester 0.
        drive(1'b1, 4'b0011, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b0, 1'b1, "ptr_zero");
        drive(1'b1, 4'b0010, 4'b0001, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b1, "own1_mid");

        // Asynchronous reset while requester 1 owns the mux.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst.gnt",  8'(gnt), 8'h0);
        check("async_rst.sel",  8'({sel1, sel2}), 8'h0);
        check("async_rst.vld",  8'(data_vld), 8'h0);
        check("async_rst.dout", 8'(data_out), 8'h0);
        drive(1'b0, 4'b1010, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "in_reset");
        drive(1'b1, 4'b1010, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0, 1'b0, "post_rst_a");
        drive(1'b1, 4'b1010, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b1, "post_rst_b");

        // Sweep every request pattern with random data, checked against the model.
        for (int p = 0; p < 16; p++)
            for (int c = 0; c < 6; c++)
                drive(1'b1, 4'(p), 4'($urandom_range(0, 15)), 1'b1, 4'b0, 2'd0, 1'b0, 1'b0, "sweep");

        @(posedge clk);
        #3;
        check("queue_drained", 8'(exp_q.size()), 8'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
